key_event_encoder: RTL
======================

Name: key_event_encoder

Overview:
- Sits directly downstream of the per-key debouncer and consumes its debounced KEYS-wide level vector.
- Converts level changes into discrete press/release events, each tagged with its key index.
- Buffers events in a first-word-fall-through FIFO behind a valid/ready interface, for the HID report or host-interface logic.
- Scans one key per clock, so there is no wide priority encoder.

Parameters:
- KEYS, 61, number of debounced key inputs.
- IDX_W, 6, key index width; must satisfy 2**IDX_W >= KEYS.
- DEPTH, 16, FIFO depth in events; must be a power of two.
- AW, 4, log2(DEPTH).

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- keys_i  input  KEYS  debounced key levels; 1 = pressed. Already synchronous to clk_i.
- evt_valid_o  output  1  FIFO head holds a valid event.
- evt_ready_i  input  1  consumer accepts the head event this cycle.
- evt_key_o  output  IDX_W  key index of the head event.
- evt_press_o  output  1  head event type; 1 = press, 0 = release.
- fifo_count_o  output  AW+1  events currently stored, 0..DEPTH.
- defer_o  output  1  sticky flag; set when a change was found while the FIFO was full.
- clr_defer_i  input  1  synchronous clear of defer_o.

Behaviour:
- Reset (asynchronous, rst_i=1). Every output and internal register is driven to its reset value while rst_i is high:
  - snapshot register prev[KEYS-1:0] = 0 (all released);
  - scan pointer = 0;
  - FIFO read/write pointers = 0; fifo_count_o = 0;
  - evt_valid_o = 0; evt_key_o = 0; evt_press_o = 0; defer_o = 0.
- Reset mid-operation: queued events are discarded. Keys held at reset release produce press events on later scan visits.
- Scan pointer:
  - advances by 1 every clock, 0..KEYS-1;
  - wraps from KEYS-1 to 0;
  - never stalls, including when the FIFO is full.
- Change detect at pointer p: change = keys_i[p] != prev[p]. Changes are evaluated only at the visited index.
- Push condition: change is true and the FIFO can accept. When pushed:
  - the FIFO stores {p, keys_i[p]};
  - prev[p] <= keys_i[p] in the same cycle.
- Change while the FIFO cannot accept:
  - no push; prev[p] is left unchanged, so the change is retried on the next visit (lossless);
  - defer_o <= 1.
- Net-change rule: a key that toggles and returns to its snapshot value between two visits produces no event.
- Accept rule: the FIFO can accept when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
- Pop: evt_valid_o && evt_ready_i.
- evt_ready_i while evt_valid_o = 0 is ignored; count never underflows.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Output interface:
  - evt_valid_o = (count != 0);
  - evt_key_o and evt_press_o show the head entry combinationally from registered state (FWFT);
  - while valid && !ready, the head is held stable.
- Latency:
  - push in cycle N makes the event visible from cycle N+1 when the FIFO was empty;
  - worst case from a keys_i change to push is KEYS cycles, with a non-full FIFO.
- Ordering: events leave in push order. Events for one key alternate press/release.
- Pointer wrap: the AW-bit FIFO pointers wrap modulo DEPTH.
- defer_o clear and set:
  - clr_defer_i clears defer_o;
  - if a set condition occurs in the same cycle as clr_defer_i, set wins.

Test Plan:
- Reset with keys_i = 0, then set key 5 = 1 at cycle 0, consumer always ready -> exactly one event {key=5, press=1} within 61 cycles; then key 5 = 0 -> exactly one {5, 0}; no other events.
- Hold keys 0, 30 and 60 at 1 through reset release -> three press events in scan order 0, 30, 60; fifo_count_o peaks at ≤3 and returns to 0.
- evt_ready_i = 0; toggle 20 distinct keys -> fifo_count_o saturates at 16 and defer_o = 1. Then assert ready -> all 20 events are delivered, none lost, with the first 16 in push order. Pulse clr_defer_i -> defer_o = 0.
- FIFO full (count 16) and pop in the same cycle as a change is visited -> push accepted, count stays 16, defer_o not set by that cycle.
- Key 7 toggles 1 then back to 0 within 10 cycles while the pointer is away from index 7 -> no event for key 7.
- Assert rst_i asynchronously mid-stream with count = 9 -> evt_valid_o falls without waiting for a clock edge and count = 0. After release, currently-pressed keys are re-reported as presses.

Source files
------------

// File: rtl/key_event_encoder.sv
// Turns debounced key levels into press/release events, scanning one key per clock,
// and queues them in a first-word-fall-through FIFO behind a valid/ready interface.
module key_event_encoder #(
    parameter int KEYS  = 61,
    parameter int IDX_W = 6,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEYS-1:0]  keys_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDX_W-1:0] evt_key_o,
    output logic             evt_press_o,
    output logic [AW:0]      fifo_count_o,
    output logic             defer_o,
    input  logic             clr_defer_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEYS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

    logic [KEYS-1:0]  r_prev;
    logic [IDX_W-1:0] r_scan;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_defer;
    logic [IDX_W:0]   r_mem [DEPTH];

    logic             w_key_now;
    logic             w_change;
    logic             w_pop;
    logic             w_can_accept;
    logic             w_push;
    logic [AW:0]      w_count_nxt;
    logic [IDX_W:0]   w_head;

    // Only the visited key is compared, so a glitch between visits is invisible.
    always_comb begin
        w_key_now    = keys_i[r_scan];
        w_change     = (w_key_now != r_prev[r_scan]);
        w_pop        = evt_valid_o && evt_ready_i;
        w_can_accept = (r_count != FULL_CNT) || w_pop;
        w_push       = w_change && w_can_accept;
    end

    // NOTE: every variable gets a default at the top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prev   <= '0;
            r_scan   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_defer  <= 1'b0;
        end else begin
            r_scan  <= (r_scan == LAST_IDX) ? '0 : r_scan + IDX_ONE;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_prev[r_scan] <= w_key_now;
                r_wr_ptr       <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // A blocked change keeps its snapshot so the next visit retries it.
            if (w_change && !w_can_accept) begin
                r_defer <= 1'b1;
            end else if (clr_defer_i) begin
                r_defer <= 1'b0;
            end
        end
    end

    // NOTE: the event storage has no reset; stale entries are never visible because the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_scan, w_key_now};
        end
    end

    always_comb begin
        w_head       = r_mem[r_rd_ptr];
        evt_valid_o  = (r_count != '0);
        evt_key_o    = evt_valid_o ? w_head[IDX_W:1] : '0;
        evt_press_o  = evt_valid_o ? w_head[0] : 1'b0;
        fifo_count_o = r_count;
        defer_o      = r_defer;
    end

endmodule
